// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver with 3-sample majority vote and a small output FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames; the default build receives 8N1.
module uart_rx_os #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] os_div,
    input  logic             Rx,
    output logic [7:0]       data_out,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic [1:0]       r_sync;
    logic [DIV_W-1:0] r_div_cnt;
    state_t           r_state;
    logic [3:0]       r_sc;
    logic             r_s7;
    logic             r_s8;
    logic             r_bit;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_frame_err;
`ifdef UART_RX_PARITY_EN
    logic             r_par;
    logic             r_par_err;
`endif

    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_overrun;

    logic             w_rxs;
    logic [DIV_W-1:0] w_div_max;
    logic             w_tick;
    logic             w_maj;
    logic             w_stop_ok;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_wr;

    assign w_rxs     = r_sync[1];
    assign w_div_max = (os_div == '0) ? DIV_W'(1) : os_div;
    // >= rather than == so a shrinking os_div cannot strand the counter above terminal count
    assign w_tick    = en && (r_div_cnt >= w_div_max - DIV_W'(1));
    assign w_maj     = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);
`ifdef UART_RX_PARITY_EN
    assign w_stop_ok = w_maj & ~r_par_err;
`else
    assign w_stop_ok = w_maj;
`endif
    assign w_push    = w_tick && (r_state == S_STOP) && (r_sc == 4'd9) && w_stop_ok;
    assign w_pop     = rx_valid && rx_ready;
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_wr      = w_push && (!w_full || w_pop);

    assign rx_valid  = (r_count != '0);
    assign data_out  = r_mem[r_rptr];
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_sync    <= 2'b11;
            r_div_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], Rx};
            if (!en || w_tick) r_div_cnt <= '0;
            else               r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // The detecting tick is sample 0 of the start bit, so sc=7..9 land mid-bit.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state     <= S_IDLE;
            r_sc        <= '0;
            r_s7        <= 1'b1;
            r_s8        <= 1'b1;
            r_bit       <= 1'b1;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par       <= 1'b0;
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            if (!en) begin
                r_state <= S_IDLE;
                r_sc    <= '0;
            end else if (w_tick) begin
                if (r_sc == 4'd7) r_s7 <= w_rxs;
                if (r_sc == 4'd8) r_s8 <= w_rxs;
                if (r_sc == 4'd9) r_bit <= w_maj;
                if (r_state != S_IDLE) r_sc <= r_sc + 4'd1;
                unique case (r_state)
                    S_IDLE: begin
                        if (!w_rxs) begin
                            r_state <= S_START;
                            r_sc    <= 4'd1;
                        end
                    end
                    S_START: begin
                        if (r_sc == 4'd15) begin
                            if (r_bit) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state   <= S_DATA;
                                r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                                r_par     <= 1'b0;
`endif
                            end
                        end
                    end
                    S_DATA: begin
                        if (r_sc == 4'd15) begin
                            r_shift   <= {r_bit, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                            r_par     <= r_par ^ r_bit;
                            if (r_bit_idx == 3'd7) r_state <= S_PARITY;
`else
                            if (r_bit_idx == 3'd7) r_state <= S_STOP;
`endif
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (r_sc == 4'd15) begin
                            r_par_err <= r_par ^ r_bit;
                            r_state   <= S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        if (r_sc == 4'd9) begin
                            r_sc <= '0;
                            if (w_stop_ok) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state     <= S_WAIT_IDLE;
                                r_frame_err <= 1'b1;
                            end
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                            r_sc    <= '0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push && !w_wr;
            if (w_wr) begin
                r_mem[r_wptr] <= r_shift;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver: the receive end of the link driven by the existing transmitter path. It samples serial `Rx` at 16× the bit rate, majority-votes each bit, checks framing, and buffers received bytes in a small FIFO read through a valid/ready handshake. It sits beside `uart_top`'s transmitter as the robust receive path for 8N1 frames, or 8E1 frames when parity is built in.

## Interface
- `DEPTH`, 4: FIFO entries; power of 2, minimum 2.
- `DIV_W`, 16: width of `os_div`.

- `clk`: in, 1. Single clock.
- `arst_n`: in, 1. Reset, synchronous, active-low.
- `en`: in, 1. Receiver enable.
- `os_div`: in, DIV_W. Clocks per oversample tick; 0 is treated as 1. Bit period is 16 × `os_div` clocks.
- `Rx`: in, 1. Asynchronous serial input; idle high.
- `data_out`: out, 8. FIFO head byte.
- `rx_valid`: out, 1. FIFO not empty.
- `rx_ready`: in, 1. Consumer accepts the head byte.
- `frame_err`: out, 1. One-cycle pulse on a bad stop bit, or on bad parity when parity is built in.
- `overrun`: out, 1. One-cycle pulse when a good byte is dropped because the FIFO is full.
- `busy`: out, 1. High whenever the receiver is not in IDLE.

## Operation
- **Synchronizer:** `Rx` passes through 2 flops, both reset to 1. All logic uses the synchronized value `rxs`.
- **Tick generator:** counter runs 0..max(`os_div`,1)−1 while `en`=1. `tick` is high for one clock at the terminal count. The counter clears when `en`=0.
- **Sample counter:** `sc` is 4 bits, advances on `tick`, and wraps 15→0. Bit value is the majority of `rxs` at `sc` = 7, 8, 9.
- **States:**
  - IDLE: `sc`=0. On `tick` with `rxs`=0, go to START.
  - START: resolve the bit at `sc`=15. Majority 1 means a glitch, so return to IDLE. Otherwise go to DATA with bit index 0.
  - DATA: resolve at `sc`=15 and shift in LSB first. After bit 7, go to PARITY if built in, else STOP.
  - PARITY: resolve at `sc`=15 and check even parity over data plus parity bit. Go to STOP.
  - STOP: resolve at `sc`=9, not 15, so the receiver can resync on the next frame.
    - Stop=1 and parity ok: push the byte and go to IDLE.
    - Otherwise: pulse `frame_err`, discard the byte, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until a `tick` sees `rxs`=1, then go to IDLE. This covers break conditions.
- **FIFO:**
  - Storage is DEPTH×8 with read/write pointers and a count.
  - `data_out` shows the head entry; it is undefined when empty.
  - Pop happens when `rx_valid`&&`rx_ready`.
  - Push while full: byte dropped, `overrun` pulses, contents unchanged.
  - Push and pop in the same cycle while full: both succeed, no overrun.
  - Push and pop in the same cycle while empty: not possible, since the push becomes visible a cycle later.
- **`en`=0:** state goes to IDLE on the next clock and any partial frame is discarded. FIFO contents and the read handshake keep working.
- **Reset (`arst_n`=0 at a clock edge):** state IDLE, counters 0, FIFO empty, synchronizer at 1. Outputs: `rx_valid`=0, `busy`=0, `frame_err`=0, `overrun`=0, `data_out`=0.

## Timing
- Input latency: a change on `Rx` appears on `rxs` after 2 clocks.
- Push occurs at the clock edge ending the stop bit's `sc`=9 tick. `rx_valid` is high in the next cycle, with `data_out` valid in that same cycle.
- Frame start to `rx_valid`: about (9.5 + 16 × nbits_before_stop) ticks plus 3 clocks, where nbits_before_stop is 9 (10 with parity).
- `frame_err` and `overrun` are asserted for exactly the cycle after the resolving edge.
- Tolerance: the receiver accepts ±3% baud mismatch over a full frame.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: frames are 8E1. The PARITY state exists, and a parity mismatch takes the frame-error path: `frame_err` pulses, the byte is discarded, and the receiver enters WAIT_IDLE.
  - Undefined: frames are 8N1. PARITY is removed and STOP follows data bit 7.
  - Ports are identical in both builds.

## Test plan
All scenarios use `clk` period 50 ns, `os_div`=8 (128 clocks/bit), DEPTH=4, and parity off unless stated.

1. **Single byte:** send 0xB4, 8N1, with `rx_ready`=1 → exactly one `rx_valid` cycle with `data_out`=0xB4. `frame_err`=0 and `overrun`=0 throughout.
2. **Framing error and recovery:** send 0xA5 with stop bit 0, hold `Rx` low for 2 bit times, then high for 1 bit, then send 0x3C → one `frame_err` pulse and no byte for 0xA5. `busy` stays high until `Rx` returns high. Then `data_out`=0x3C is received.
3. **Start glitch rejection:** pulse `Rx` low for 40 clocks while idle → `busy` rises, then falls within 16 ticks. No `rx_valid` and no `frame_err`.
4. **Overrun:** hold `rx_ready`=0 and send 0x01..0x05 back-to-back → `rx_valid` stays high after the first byte, and `overrun` pulses once, during the 5th stop bit. Then set `rx_ready`=1: pops yield 0x01, 0x02, 0x03, 0x04, after which `rx_valid`=0.
5. **Reset mid-frame:** assert `arst_n`=0 for 1 clock during data bit 3 of 0xFF → next cycle `busy`=0 and `rx_valid`=0. A following 0x5A is received intact.
6. **Parity (`UART_RX_PARITY_EN` defined):**
   - Send 0x07 with parity bit 1 → `data_out`=0x07.
   - Send 0x07 with parity bit 0 → `frame_err` pulses once and no byte is pushed.
